// File: rtl/data_mem_if.sv
// Load/store request and response channels between the CPU datapath and its data memory.
// Each channel uses a valid/ready handshake.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data RAM that answers one load/store at a time.
// Each response arrives LATENCY cycles after the request is accepted.
module data_memory_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            lat_write;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [31:0]     rdata;
    logic            err;
    logic [31:0]     mem [DEPTH];
    logic            access;
    logic            bad;
    logic [AW-1:0]   widx;

    // Full 30-bit word index compare so high addresses never alias low words.
    assign bad    = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
    assign widx   = lat_addr[AW+1:2];
    assign access = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = BUSY;
            BUSY:    if (access)        state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    lat_write <= bus.req_write;
                    lat_addr  <= bus.req_addr;
                    lat_wdata <= bus.req_wdata;
                    cnt       <= CW'(LATENCY - 1);
                end
                BUSY: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    err   <= bad;
                    rdata <= (!bad && !lat_write) ? mem[widx] : '0;
                end
                RESP: if (bus.rsp_ready) begin
                    rdata <= '0;
                    err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // RAM has no reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && access && !bad && lat_write)
            mem[widx] <= lat_wdata;
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder against an array-based memory model.
// LATENCY=1 and LATENCY=4 instances share the stimulus for timing checks.
module tb_data_memory_responder;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_if b2();
    data_mem_if b1();
    data_mem_if b4();

    assign b1.req_valid = b2.req_valid;
    assign b1.req_write = b2.req_write;
    assign b1.req_addr  = b2.req_addr;
    assign b1.req_wdata = b2.req_wdata;
    assign b1.rsp_ready = b2.rsp_ready;
    assign b4.req_valid = b2.req_valid;
    assign b4.req_write = b2.req_write;
    assign b4.req_addr  = b2.req_addr;
    assign b4.req_wdata = b2.req_wdata;
    assign b4.rsp_ready = b2.rsp_ready;

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(1))   dut1 (.clk(clk), .reset(reset), .bus(b1));
    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(4))   dut4 (.clk(clk), .reset(reset), .bus(b4));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference memory: only words written through the bus are known.
    logic [31:0] mmem [DEPTH];
    bit          mknown [DEPTH];
    int          last_acc = 0;
    int          prev_acc = 0;

    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input bit keep_req);
        bit          err_e;
        bit          chk_rd;
        logic [31:0] rd_e;
        int          idx;
        int          n;
        err_e  = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        idx    = int'(a >> 2);
        chk_rd = 1'b1;
        rd_e   = '0;
        if (!err_e && !wr) begin
            if (mknown[idx]) rd_e = mmem[idx];
            else             chk_rd = 1'b0;
        end
        if (!err_e && wr) begin
            mmem[idx]   = d;
            mknown[idx] = 1'b1;
        end
        b2.req_valid = 1'b1;
        b2.req_write = wr;
        b2.req_addr  = a;
        b2.req_wdata = d;
        chk("idle_req_ready", 32'(b2.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        prev_acc = last_acc;
        last_acc = cyc;
        n = 0;
        while (!b2.rsp_valid && n < 20) begin
            chk("busy_req_ready", 32'(b2.req_ready), 32'd0);
            b2.rsp_ready = 1'($urandom_range(0, 1));
            if (!keep_req) begin
                b2.req_valid = 1'($urandom_range(0, 1));
                b2.req_write = 1'($urandom_range(0, 1));
                b2.req_addr  = $urandom;
                b2.req_wdata = $urandom;
            end
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        chk("rsp_err", 32'(b2.rsp_err), 32'(err_e));
        if (chk_rd) chk("rsp_rdata", b2.rsp_rdata, rd_e);
        chk("resp_req_ready", 32'(b2.req_ready), 32'd0);
        rd_e = b2.rsp_rdata;
        b2.rsp_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(b2.rsp_valid), 32'd1);
            chk("hold_rdata", b2.rsp_rdata, rd_e);
            chk("hold_err", 32'(b2.rsp_err), 32'(err_e));
        end
        b2.rsp_ready = 1'b1;
        if (!keep_req) b2.req_valid = 1'b0;
        @(negedge clk);
        b2.rsp_ready = 1'b0;
        chk("post_valid", 32'(b2.rsp_valid), 32'd0);
        chk("post_rdata", b2.rsp_rdata, 32'd0);
        chk("post_err", 32'(b2.rsp_err), 32'd0);
        chk("post_req_ready", 32'(b2.req_ready), 32'd1);
    endtask

    // Accept / rsp_valid-rise timestamps for all three latency builds.
    bit         mon_en = 1'b0;
    logic [2:0] acc_now, val_now;
    bit   [2:0] val_prev = '0;
    int         accq [3][$];
    int         riseq [3][$];
    assign acc_now = {b4.req_valid & b4.req_ready, b1.req_valid & b1.req_ready, b2.req_valid & b2.req_ready};
    assign val_now = {b4.rsp_valid, b1.rsp_valid, b2.rsp_valid};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mon_en && acc_now[k]) accq[k].push_back(cyc);
            if (mon_en && val_now[k] && !val_prev[k]) riseq[k].push_back(cyc);
        end
        val_prev = val_now;
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        b2.req_valid = 1'b0;
        b2.req_write = 1'b0;
        b2.req_addr  = '0;
        b2.req_wdata = '0;
        b2.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(b2.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", b2.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(b2.rsp_err), 32'd0);
        reset = 1'b0;

        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0);

        do_txn(1'b1, 32'h0,  32'h0BADF00D, 0, 1'b0);
        do_txn(1'b1, 32'hFC, 32'h55AA55AA, 1, 1'b0);
        do_txn(1'b0, 32'h12, 32'h0, 0, 1'b0);
        do_txn(1'b0, 32'h100, 32'h0, 0, 1'b0);
        do_txn(1'b1, 32'h102, 32'hFFFFFFFF, 0, 1'b0);
        do_txn(1'b1, 32'h100, 32'hCAFEF00D, 0, 1'b0);
        do_txn(1'b1, 32'h8000_0010, 32'h11111111, 0, 1'b0);
        do_txn(1'b0, 32'h0,  32'h0, 0, 1'b0);
        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0);
        do_txn(1'b0, 32'hFC, 32'h0, 0, 1'b0);

        do_txn(1'b0, 32'h10, 32'h0, 5, 1'b1);
        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b1);
        chk("gap_after_hold", 32'(last_acc - prev_acc), 32'(LAT + 2 + 5));
        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0);
        chk("gap_back_to_back", 32'(last_acc - prev_acc), 32'(LAT + 2));

        do_txn(1'b1, 32'h20, 32'hA5A5A5A5, 0, 1'b0);
        b2.req_valid = 1'b1;
        b2.req_write = 1'b1;
        b2.req_addr  = 32'h20;
        b2.req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        b2.req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_req_ready", 32'(b2.req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        repeat (4) @(negedge clk);
        do_txn(1'b0, 32'h20, 32'h0, 0, 1'b0);

        repeat (40) begin
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, 255));
                1:       a = 32'($urandom_range(64, 80)) << 2;
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, 15)) << 2;
            endcase
            do_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b0);
        end

        reset = 1'b1;
        b2.req_valid = 1'b0;
        b2.rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        b2.req_valid = 1'b1;
        b2.req_write = 1'b0;
        b2.req_addr  = 32'h10;
        repeat (30) @(posedge clk);
        #1;
        mon_en = 1'b0;
        b2.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mon_count", 32'(accq[k].size() >= 3 && riseq[k].size() >= 3), 32'd1);
            if (accq[k].size() >= 3 && riseq[k].size() >= 3) begin
                for (int j = 0; j < 3; j++)
                    chk($sformatf("lat%0d_rise", lat_of(k)), 32'(riseq[k][j] - accq[k][j]), 32'(lat_of(k) + 1));
                for (int j = 1; j < 3; j++)
                    chk($sformatf("lat%0d_gap", lat_of(k)), 32'(accq[k][j] - accq[k][j-1]), 32'(lat_of(k) + 2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
